// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared grant encodings, arbiter states and timing defaults
package eth_pkg;

    localparam logic [1:0] GNT_NONE = 2'd0;
    localparam logic [1:0] GNT_ARP  = 2'd1;
    localparam logic [1:0] GNT_ICMP = 2'd2;
    localparam logic [1:0] GNT_UDP  = 2'd3;

    localparam int IFG_CYC_DEF     = 12;
    localparam int TIMEOUT_CYC_DEF = 4096;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_BUSY,
        ST_GAP
    } arb_state_t;

endpackage

// File: rtl/eth_tx_req_latch.sv
// rtl/eth_tx_req_latch.sv - one-deep pending request latch with overflow pulse and payload
module eth_tx_req_latch #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_req,
    input  logic [W-1:0] i_payload,
    input  logic         i_clr,
    output logic         o_pend,
    output logic [W-1:0] o_payload,
    output logic         o_ovf
);

    logic         r_pend;
    logic [W-1:0] r_payload;
    logic         r_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pend    <= 1'b0;
            r_payload <= '0;
            r_ovf     <= 1'b0;
        end else begin
            // a request on the clearing edge re-arms the latch rather than being dropped
            r_ovf <= i_req && r_pend && !i_clr;
            if (i_req) begin
                r_pend <= 1'b1;
                if (!r_pend || i_clr) begin
                    r_payload <= i_payload;
                end
            end else if (i_clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pend    = r_pend;
    assign o_payload = r_payload;
    assign o_ovf     = r_ovf;

endmodule

// File: rtl/eth_tx_arbiter.sv
// rtl/eth_tx_arbiter.sv - fixed-priority GMII/FIFO transmit arbiter for ARP, ICMP and UDP engines
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int IFG_CYC     = IFG_CYC_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       arp_req,
    input  logic       arp_req_type,
    output logic       arp_tx_en,
    output logic       arp_tx_type,
    input  logic       arp_tx_done,
    input  logic       arp_gmii_tx_en,
    input  logic [7:0] arp_gmii_txd,
    input  logic       icmp_req,
    output logic       icmp_tx_start_en,
    input  logic       icmp_tx_done,
    input  logic       icmp_gmii_tx_en,
    input  logic [7:0] icmp_gmii_txd,
    input  logic       icmp_tx_req,
    output logic [7:0] icmp_tx_data,
    input  logic       udp_req,
    output logic       udp_tx_start_en,
    input  logic       udp_tx_done,
    input  logic       udp_gmii_tx_en,
    input  logic [7:0] udp_gmii_txd,
    input  logic       udp_tx_req,
    output logic [7:0] udp_tx_data,
    output logic       tx_req,
    input  logic [7:0] tx_data,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err,
    output logic       req_ovf
);

    localparam logic [15:0] IFG_LAST = 16'(IFG_CYC - 1);
    localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYC - 1);

    arb_state_t  r_state;
    logic [1:0]  r_grant;
    logic        r_busy;
    logic [15:0] r_cnt;
    logic        r_arp_start, r_icmp_start, r_udp_start;
    logic        r_timeout_err;
    logic        r_gmii_tx_en;
    logic [7:0]  r_gmii_txd;

    logic w_arp_pend, w_icmp_pend, w_udp_pend;
    logic w_arp_clr, w_icmp_clr, w_udp_clr;
    logic w_arp_ovf, w_icmp_ovf, w_udp_ovf;
    logic w_icmp_pay_unused, w_udp_pay_unused;
    logic w_idle, w_pass, w_done, w_gnt_en, w_gnt_rd;
    logic [7:0] w_gnt_txd;

    eth_tx_req_latch #(.W(1)) u_arp_latch (
        .clk(clk), .rst_n(rst_n), .i_req(arp_req), .i_payload(arp_req_type), .i_clr(w_arp_clr),
        .o_pend(w_arp_pend), .o_payload(arp_tx_type), .o_ovf(w_arp_ovf)
    );

    eth_tx_req_latch #(.W(1)) u_icmp_latch (
        .clk(clk), .rst_n(rst_n), .i_req(icmp_req), .i_payload(1'b0), .i_clr(w_icmp_clr),
        .o_pend(w_icmp_pend), .o_payload(w_icmp_pay_unused), .o_ovf(w_icmp_ovf)
    );

    eth_tx_req_latch #(.W(1)) u_udp_latch (
        .clk(clk), .rst_n(rst_n), .i_req(udp_req), .i_payload(1'b0), .i_clr(w_udp_clr),
        .o_pend(w_udp_pend), .o_payload(w_udp_pay_unused), .o_ovf(w_udp_ovf)
    );

    // the winner's pending bit is cleared on the same edge that moves IDLE to START
    assign w_idle     = (r_state == ST_IDLE);
    assign w_arp_clr  = w_idle && w_arp_pend;
    assign w_icmp_clr = w_idle && !w_arp_pend && w_icmp_pend;
    assign w_udp_clr  = w_idle && !w_arp_pend && !w_icmp_pend && w_udp_pend;
    assign w_pass     = (r_state == ST_START) || (r_state == ST_BUSY);

    always_comb begin
        w_done    = 1'b0;
        w_gnt_en  = 1'b0;
        w_gnt_txd = 8'h00;
        w_gnt_rd  = 1'b0;
        case (r_grant)
            GNT_ARP: begin
                w_done    = arp_tx_done;
                w_gnt_en  = arp_gmii_tx_en;
                w_gnt_txd = arp_gmii_txd;
            end
            GNT_ICMP: begin
                w_done    = icmp_tx_done;
                w_gnt_en  = icmp_gmii_tx_en;
                w_gnt_txd = icmp_gmii_txd;
                w_gnt_rd  = icmp_tx_req;
            end
            GNT_UDP: begin
                w_done    = udp_tx_done;
                w_gnt_en  = udp_gmii_tx_en;
                w_gnt_txd = udp_gmii_txd;
                w_gnt_rd  = udp_tx_req;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= GNT_NONE;
            r_busy        <= 1'b0;
            r_cnt         <= 16'd0;
            r_arp_start   <= 1'b0;
            r_icmp_start  <= 1'b0;
            r_udp_start   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_gmii_tx_en  <= 1'b0;
            r_gmii_txd    <= 8'h00;
        end else begin
            r_arp_start   <= 1'b0;
            r_icmp_start  <= 1'b0;
            r_udp_start   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_gmii_tx_en  <= w_pass && w_gnt_en;
            r_gmii_txd    <= w_pass ? w_gnt_txd : 8'h00;
            case (r_state)
                ST_IDLE: begin
                    if (w_arp_pend || w_icmp_pend || w_udp_pend) begin
                        r_state      <= ST_START;
                        r_busy       <= 1'b1;
                        r_cnt        <= 16'd0;
                        r_grant      <= w_arp_clr ? GNT_ARP : (w_icmp_clr ? GNT_ICMP : GNT_UDP);
                        r_arp_start  <= w_arp_clr;
                        r_icmp_start <= w_icmp_clr;
                        r_udp_start  <= w_udp_clr;
                    end
                end
                ST_START: begin
                    r_state <= ST_BUSY;
                    r_cnt   <= r_cnt + 16'd1;
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_state <= ST_GAP;
                        r_grant <= GNT_NONE;
                        r_cnt   <= 16'd0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state       <= ST_GAP;
                        r_grant       <= GNT_NONE;
                        r_cnt         <= 16'd0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                ST_GAP: begin
                    if (r_cnt == IFG_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign arp_tx_en        = r_arp_start;
    assign icmp_tx_start_en = r_icmp_start;
    assign udp_tx_start_en  = r_udp_start;
    assign grant            = r_grant;
    assign busy             = r_busy;
    assign timeout_err      = r_timeout_err;
    assign gmii_tx_en       = r_gmii_tx_en;
    assign gmii_txd         = r_gmii_txd;
    assign req_ovf          = w_arp_ovf || w_icmp_ovf || w_udp_ovf;
    assign tx_req           = (r_state == ST_BUSY) && w_gnt_rd;
    assign icmp_tx_data     = tx_data;
    assign udp_tx_data      = tx_data;

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb/tb_eth_tx_arbiter.sv - randomized self-checking bench for eth_tx_arbiter
module tb_eth_tx_arbiter;

    localparam int IFG = 12;
    localparam int TO  = 4096;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       arp_req, arp_req_type, arp_tx_en, arp_tx_type, arp_tx_done, arp_gmii_tx_en;
    logic [7:0] arp_gmii_txd;
    logic       icmp_req, icmp_tx_start_en, icmp_tx_done, icmp_gmii_tx_en, icmp_tx_req;
    logic [7:0] icmp_gmii_txd, icmp_tx_data;
    logic       udp_req, udp_tx_start_en, udp_tx_done, udp_gmii_tx_en, udp_tx_req;
    logic [7:0] udp_gmii_txd, udp_tx_data;
    logic       tx_req, gmii_tx_en, busy, timeout_err, req_ovf;
    logic [7:0] tx_data, gmii_txd;
    logic [1:0] grant;

    logic [2:0] eng_en, eng_done, active, hang;
    logic [7:0] eng_txd [3];
    int         len [3];
    int         rem [3];
    int         done_edge [3];

    typedef struct { int c; logic [7:0] d; } byte_t;
    typedef struct { int e; int c; logic t; } start_t;
    byte_t  exp_q[$];
    start_t start_log[$];
    int     cyc, n_pass, n_total;

    always #4 clk = ~clk;

    assign arp_gmii_tx_en  = eng_en[0];
    assign icmp_gmii_tx_en = eng_en[1];
    assign udp_gmii_tx_en  = eng_en[2];
    assign arp_gmii_txd    = eng_txd[0];
    assign icmp_gmii_txd   = eng_txd[1];
    assign udp_gmii_txd    = eng_txd[2];
    assign arp_tx_done     = eng_done[0];
    assign icmp_tx_done    = eng_done[1];
    assign udp_tx_done     = eng_done[2];

    eth_tx_arbiter #(.IFG_CYC(IFG), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .arp_req(arp_req), .arp_req_type(arp_req_type), .arp_tx_en(arp_tx_en), .arp_tx_type(arp_tx_type),
        .arp_tx_done(arp_tx_done), .arp_gmii_tx_en(arp_gmii_tx_en), .arp_gmii_txd(arp_gmii_txd),
        .icmp_req(icmp_req), .icmp_tx_start_en(icmp_tx_start_en), .icmp_tx_done(icmp_tx_done),
        .icmp_gmii_tx_en(icmp_gmii_tx_en), .icmp_gmii_txd(icmp_gmii_txd), .icmp_tx_req(icmp_tx_req),
        .icmp_tx_data(icmp_tx_data),
        .udp_req(udp_req), .udp_tx_start_en(udp_tx_start_en), .udp_tx_done(udp_tx_done),
        .udp_gmii_tx_en(udp_gmii_tx_en), .udp_gmii_txd(udp_gmii_txd), .udp_tx_req(udp_tx_req),
        .udp_tx_data(udp_tx_data),
        .tx_req(tx_req), .tx_data(tx_data), .gmii_tx_en(gmii_tx_en), .gmii_txd(gmii_txd),
        .grant(grant), .busy(busy), .timeout_err(timeout_err), .req_ovf(req_ovf)
    );

    // One clock: sample after the edge, check GMII bytes, log starts, then step the engine models.
    task automatic tick();
        logic [2:0] st;
        byte_t      b;
        start_t     sl;
        @(posedge clk);
        #1;
        cyc++;
        if (gmii_tx_en) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL gmii_extra: got byte %02h at cycle %0d, required no byte", gmii_txd, cyc);
            end else begin
                b = exp_q.pop_front();
                if (b.c !== cyc || b.d !== gmii_txd)
                    $display("FAIL gmii_lag: got %02h at cycle %0d, required %02h at cycle %0d", gmii_txd, cyc, b.d, b.c);
                else
                    n_pass++;
            end
        end
        st = {udp_tx_start_en, icmp_tx_start_en, arp_tx_en};
        for (int e = 0; e < 3; e++) begin
            eng_en[e]   = 1'b0;
            eng_done[e] = 1'b0;
            eng_txd[e]  = 8'h00;
            if (st[e]) begin
                sl.e = e; sl.c = cyc; sl.t = arp_tx_type;
                start_log.push_back(sl);
                active[e] = 1'b1;
                rem[e]    = len[e];
            end
            if (active[e]) begin
                if (rem[e] > 0) begin
                    eng_en[e]  = 1'b1;
                    eng_txd[e] = 8'($urandom);
                    b.c = cyc + 1; b.d = eng_txd[e];
                    exp_q.push_back(b);
                    rem[e]--;
                end else if (!hang[e]) begin
                    eng_done[e]  = 1'b1;
                    done_edge[e] = cyc + 1;
                    active[e]    = 1'b0;
                end
            end
        end
    endtask

    task automatic pulse_req(input logic [2:0] mask, input logic typ);
        arp_req = mask[0]; arp_req_type = typ; icmp_req = mask[1]; udp_req = mask[2];
        tick();
        arp_req = 1'b0; arp_req_type = 1'b0; icmp_req = 1'b0; udp_req = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int max_cyc, input string tag);
        int i = 0;
        while (start_log.size() < n && i < max_cyc) begin tick(); i++; end
        n_total++;
        if (start_log.size() < n) $display("FAIL %s_start_wait: got %0d starts, required %0d", tag, start_log.size(), n);
        else n_pass++;
    endtask

    task automatic wait_quiet(input int max_cyc, input string tag);
        int i = 0;
        while ((busy || active != 3'b000) && i < max_cyc) begin tick(); i++; end
        n_total++;
        if (busy !== 1'b0 || active != 3'b000) $display("FAIL %s_quiet: got busy %b, required 0 within %0d cycles", tag, busy, max_cyc);
        else n_pass++;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_total++;
        if ({arp_tx_en, arp_tx_type, icmp_tx_start_en, udp_tx_start_en, tx_req, gmii_tx_en, gmii_txd, timeout_err, req_ovf} !== 16'h0)
            $display("FAIL reset_outputs: got %b, required all zero",
                     {arp_tx_en, arp_tx_type, icmp_tx_start_en, udp_tx_start_en, tx_req, gmii_tx_en, gmii_txd, timeout_err, req_ovf});
        else n_pass++;
        n_total++;
        if (grant !== 2'd0 || busy !== 1'b0) $display("FAIL reset_state: got grant %0d busy %b, required 0 0", grant, busy);
        else n_pass++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_udp();
        int rc, base, i, d;
        len[2] = $urandom_range(4, 20);
        tick(); tick();
        base = start_log.size();
        rc   = cyc;
        pulse_req(3'b100, 1'b0);
        wait_starts(base + 1, 10, "udp");
        if (start_log.size() > base) begin
            n_total++;
            if (start_log[base].e !== 2 || start_log[base].c !== rc + 2)
                $display("FAIL udp_start_latency: got engine %0d at cycle %0d, required engine 2 at cycle %0d",
                         start_log[base].e, start_log[base].c, rc + 2);
            else n_pass++;
            n_total++;
            if (grant !== 2'd3 || busy !== 1'b1) $display("FAIL udp_grant: got grant %0d busy %b, required 3 1", grant, busy);
            else n_pass++;
            i = 0;
            while (active[2] && i < 64) begin tick(); i++; end
            d = done_edge[2];
            for (int k = 0; k < IFG; k++) begin
                tick();
                n_total++;
                if (gmii_tx_en !== 1'b0 || grant !== 2'd0 || busy !== 1'b1)
                    $display("FAIL udp_gap: got en %b grant %0d busy %b at cycle %0d, required 0 0 1", gmii_tx_en, grant, busy, cyc);
                else n_pass++;
            end
            tick();
            n_total++;
            if (busy !== 1'b0 || cyc !== d + IFG) $display("FAIL udp_gap_end: got busy %b at cycle %0d, required 0 at cycle %0d", busy, cyc, d + IFG);
            else n_pass++;
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL udp_bytes_left: got %0d unsent bytes, required 0", exp_q.size());
        else n_pass++;
    endtask

    // Requests raised together are served in priority order; each later start follows the previous done + IFG + 1.
    task automatic run_round(input logic [2:0] mask, input logic typ);
        int base, rc, expc;
        int ids[$];
        for (int e = 0; e < 3; e++) begin
            len[e] = $urandom_range(1, 24);
            if (mask[e]) ids.push_back(e);
        end
        base = start_log.size();
        rc   = cyc;
        pulse_req(mask, typ);
        wait_starts(base + ids.size(), ids.size() * (24 + IFG + 8) + 8, "round");
        wait_quiet(24 + IFG + 8, "round");
        n_total++;
        if (start_log.size() != base + ids.size()) $display("FAIL round_count: got %0d starts, required %0d", start_log.size() - base, ids.size());
        else n_pass++;
        for (int k = 0; k < ids.size() && base + k < start_log.size(); k++) begin
            if (k == 0) expc = rc + 2;
            else expc = done_edge[ids[k-1]] + IFG + 1;
            n_total++;
            if (start_log[base+k].e !== ids[k] || start_log[base+k].c !== expc)
                $display("FAIL round_order: got engine %0d at cycle %0d, required engine %0d at cycle %0d",
                         start_log[base+k].e, start_log[base+k].c, ids[k], expc);
            else n_pass++;
            if (ids[k] == 0) begin
                n_total++;
                if (start_log[base+k].t !== typ) $display("FAIL arp_type: got %b, required %b", start_log[base+k].t, typ);
                else n_pass++;
            end
        end
        n_total++;
        if (exp_q.size() != 0) $display("FAIL round_bytes_left: got %0d unsent bytes, required 0", exp_q.size());
        else n_pass++;
    endtask

    task automatic test_ovf();
        int base;
        len[0] = 16;
        len[1] = $urandom_range(2, 10);
        base = start_log.size();
        pulse_req(3'b001, 1'b0);
        repeat (3) tick();
        pulse_req(3'b010, 1'b0);
        n_total++;
        if (req_ovf !== 1'b0) $display("FAIL ovf_first: got %b, required 0", req_ovf);
        else n_pass++;
        tick();
        pulse_req(3'b010, 1'b0);
        n_total++;
        if (req_ovf !== 1'b1) $display("FAIL ovf_second: got %b, required 1", req_ovf);
        else n_pass++;
        tick();
        n_total++;
        if (req_ovf !== 1'b0) $display("FAIL ovf_one_cycle: got %b, required 0", req_ovf);
        else n_pass++;
        wait_starts(base + 2, 100, "ovf");
        wait_quiet(60, "ovf");
        n_total++;
        if (start_log.size() != base + 2 || start_log[base+1].e !== 1)
            $display("FAIL ovf_frames: got %0d starts, required 2 (ARP then one ICMP)", start_log.size() - base);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int base, s, i;
        len[2]  = $urandom_range(2, 8);
        len[0]  = $urandom_range(1, 8);
        hang[2] = 1'b1;
        base = start_log.size();
        pulse_req(3'b100, 1'b0);
        wait_starts(base + 1, 10, "to");
        s = cyc;
        repeat ($urandom_range(5, 50)) tick();
        pulse_req(3'b001, 1'b1);
        i = 0;
        while (!timeout_err && i < TO + 20) begin tick(); i++; end
        n_total++;
        if (timeout_err !== 1'b1 || cyc !== s + TO)
            $display("FAIL timeout_at: got err %b at cycle %0d, required 1 at cycle %0d", timeout_err, cyc, s + TO);
        else n_pass++;
        n_total++;
        if (grant !== 2'd0) $display("FAIL timeout_grant: got %0d, required 0", grant);
        else n_pass++;
        hang[2]   = 1'b0;
        active[2] = 1'b0;
        tick();
        n_total++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_pulse: got %b, required 0", timeout_err);
        else n_pass++;
        wait_starts(base + 2, IFG + 10, "to_arp");
        if (start_log.size() > base + 1) begin
            n_total++;
            if (start_log[base+1].e !== 0 || start_log[base+1].c !== s + TO + IFG + 1 || start_log[base+1].t !== 1'b1)
                $display("FAIL timeout_next: got engine %0d at cycle %0d, required engine 0 at cycle %0d",
                         start_log[base+1].e, start_log[base+1].c, s + TO + IFG + 1);
            else n_pass++;
        end
        wait_quiet(40, "to");
    endtask

    task automatic test_fifo_mux();
        int base, i;
        len[1] = 24;
        base = start_log.size();
        pulse_req(3'b010, 1'b0);
        wait_starts(base + 1, 10, "fifo");
        icmp_tx_req = 1'b1; udp_tx_req = 1'b1; tx_data = 8'hA5;
        #1;
        n_total++;
        if (tx_req !== 1'b0) $display("FAIL fifo_start_blocked: got %b, required 0", tx_req);
        else n_pass++;
        for (int k = 1; k < 24; k++) begin
            tick();
            icmp_tx_req = 1'($urandom);
            udp_tx_req  = 1'($urandom);
            tx_data     = (k == 1) ? 8'hA5 : 8'($urandom);
            #1;
            n_total++;
            if (tx_req !== icmp_tx_req || icmp_tx_data !== tx_data || udp_tx_data !== tx_data)
                $display("FAIL fifo_mux: got req %b data %02h/%02h, required req %b data %02h",
                         tx_req, icmp_tx_data, udp_tx_data, icmp_tx_req, tx_data);
            else n_pass++;
        end
        i = 0;
        while ((active[1] || cyc < done_edge[1]) && i < 8) begin tick(); i++; end
        icmp_tx_req = 1'b1; udp_tx_req = 1'b1;
        #1;
        n_total++;
        if (tx_req !== 1'b0) $display("FAIL fifo_gap_blocked: got %b, required 0", tx_req);
        else n_pass++;
        icmp_tx_req = 1'b0; udp_tx_req = 1'b0;
        wait_quiet(IFG + 8, "fifo");
    endtask

    task automatic test_reset_midframe();
        int base;
        len[2] = 30;
        base = start_log.size();
        pulse_req(3'b100, 1'b0);
        wait_starts(base + 1, 10, "rst");
        repeat ($urandom_range(3, 10)) tick();
        pulse_req(3'b010, 1'b0);
        tick();
        rst_n = 1'b0;
        tick();
        n_total++;
        if ({arp_tx_en, icmp_tx_start_en, udp_tx_start_en, tx_req, gmii_tx_en, gmii_txd, timeout_err, req_ovf, grant, busy} !== 18'h0)
            $display("FAIL reset_midframe: got %b, required all zero",
                     {arp_tx_en, icmp_tx_start_en, udp_tx_start_en, tx_req, gmii_tx_en, gmii_txd, timeout_err, req_ovf, grant, busy});
        else n_pass++;
        rst_n  = 1'b1;
        active = 3'b000;
        eng_en = 3'b000;
        exp_q.delete();
        repeat (IFG + 10) tick();
        n_total++;
        if (start_log.size() != base + 1 || busy !== 1'b0)
            $display("FAIL reset_pending_lost: got %0d extra starts busy %b, required 0 0", start_log.size() - base - 1, busy);
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        arp_req = 1'b0; arp_req_type = 1'b0; icmp_req = 1'b0; udp_req = 1'b0;
        icmp_tx_req = 1'b0; udp_tx_req = 1'b0; tx_data = 8'h00;
        eng_en = 3'b000; eng_done = 3'b000; active = 3'b000; hang = 3'b000;
        for (int e = 0; e < 3; e++) begin
            eng_txd[e] = 8'h00; len[e] = 1; rem[e] = 0; done_edge[e] = 0;
        end
        cyc = 0; n_pass = 0; n_total = 0;

        test_reset();
        test_single_udp();
        run_round(3'b111, 1'b1);
        for (int r = 0; r < 5; r++) begin
            run_round(3'($urandom_range(1, 7)), 1'($urandom));
        end
        test_ovf();
        test_timeout();
        test_fifo_mux();
        test_reset_midframe();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
# eth_tx_arbiter

Transmit-side arbiter that shares the single GMII transmit path and the shared loop-back data FIFO among the ARP, ICMP and UDP frame engines. Engines raise one-cycle requests; the arbiter queues them, grants one engine at a time by fixed priority, and issues that engine's start pulse. While granted, the engine's GMII bytes and FIFO read strobe are muxed through. After each frame it enforces an inter-frame gap, and it aborts grants that exceed a frame-length watchdog. It sits between the protocol engines and the SGMII/GMII converter, in the `gmii_tx_clk` domain.

## Interface
- `IFG_CYC`, 12, idle cycles forced between frames (1..255)
- `TIMEOUT_CYC`, 4096, max cycles from start pulse to engine done (2..65535)
- `clk`  in  1  GMII transmit clock, 125 MHz
- `rst_n`  in  1  synchronous, active-low reset
- `arp_req`, `arp_req_type`  in  1,1  ARP send request pulse; type 0 = request, 1 = reply
- `arp_tx_en`, `arp_tx_type`  out  1,1  ARP start pulse; latched type
- `arp_tx_done`  in  1  ARP frame complete pulse
- `arp_gmii_tx_en`, `arp_gmii_txd`  in  1,8  ARP GMII output
- `icmp_req`  in  1  ICMP send request pulse
- `icmp_tx_start_en`  out  1  ICMP start pulse
- `icmp_tx_done`  in  1  ICMP frame complete pulse
- `icmp_gmii_tx_en`, `icmp_gmii_txd`  in  1,8  ICMP GMII output
- `icmp_tx_req`  in  1  ICMP FIFO read strobe
- `icmp_tx_data`  out  8  FIFO data to ICMP
- `udp_req`, `udp_tx_start_en`, `udp_tx_done`, `udp_gmii_tx_en`, `udp_gmii_txd`, `udp_tx_req`, `udp_tx_data`: same as the ICMP ports, for UDP
- `tx_req`  out  1  shared FIFO read enable
- `tx_data`  in  8  shared FIFO read data
- `gmii_tx_en`, `gmii_txd`  out  1,8  GMII output to the converter
- `grant`  out  2  current owner: 0 none, 1 ARP, 2 ICMP, 3 UDP
- `busy`  out  1  high when state is not IDLE
- `timeout_err`  out  1  one-cycle pulse on watchdog abort
- `req_ovf`  out  1  one-cycle pulse when a request hits an already-pending channel

## Operation
- **Pending latches.** There is one pending bit per channel.
  - The bit is set at the edge that samples its request pulse.
  - It is cleared at the edge that enters START for that channel.
  - If a request arrives while the bit is already set, the request is dropped and `req_ovf` pulses.
  - If a request and the clear arrive in the same cycle, the bit stays set.
  - The ARP pending latch also stores `arp_req_type`. `arp_tx_type` is driven from that latch.
- **Priority.** Fixed: ARP > ICMP > UDP. Priority is evaluated only in IDLE.
- **States.**
  - IDLE: if any bit is pending, load `grant` with the winner and go to START.
  - START: the selected start output is high for exactly this one cycle. Go to BUSY.
  - BUSY:
    - A done pulse from the granted engine goes to GAP.
    - Done pulses from non-granted engines are ignored.
  - GAP: hold for `IFG_CYC` cycles, with `grant` = 0, then go to IDLE.
- **Watchdog.** A cycle counter is cleared on entry to START and counts through START and BUSY. When it reaches `TIMEOUT_CYC` without a granted done, the arbiter pulses `timeout_err` and goes to GAP. The engine is not reset.
- **GMII mux.** In START and BUSY, the granted engine's en/txd pass through a register. Otherwise the inputs to that register are 0.
- **FIFO mux.** Combinational, zero latency:
  - `tx_req` = granted engine's read strobe in BUSY, else 0.
  - `tx_data` is broadcast to both `icmp_tx_data` and `udp_tx_data`.
- **Reset.** `rst_n` low forces the following values at the next edge, including mid-frame:
  - state = IDLE and all pending bits = 0;
  - `grant` = 0;
  - all outputs = 0;
  - counters = 0.

## Timing
- Request pulse sampled at edge k → pending set at k. At edge k+1, IDLE → START. Start pulse is high in cycle k+1..k+2.
- Start-pulse latency from an uncontended request is 2 cycles.
- `gmii_tx_en`/`gmii_txd` lag the engine by exactly 1 cycle.
- Done sampled at edge d → GAP. IDLE is reached at edge d+`IFG_CYC`. The next start pulse is at d+`IFG_CYC`+1 at the earliest.
- `busy` and `grant` are registered and change only on state transitions.

## Structure
- Shared package `eth_pkg` holds:
  - grant encoding constants (`GNT_NONE`/`GNT_ARP`/`GNT_ICMP`/`GNT_UDP`);
  - the arbiter state enum (IDLE/START/BUSY/GAP);
  - the `IFG_CYC` and `TIMEOUT_CYC` defaults.
- Sub-module `eth_tx_req_latch` (pending bit plus overflow detect) is instantiated three times. The ARP instance carries a 1-bit payload for the type.
- The FSM, muxes and counters stay in the top level.

## Test plan
- Single UDP request at cycle 10 → `udp_tx_start_en` is high in cycle 12 only. Then:
  - `gmii_txd` equals `udp_gmii_txd` delayed 1 cycle;
  - after `udp_tx_done`, `gmii_tx_en` stays 0 for 12 cycles.
- ARP (type 1), ICMP and UDP requests in the same cycle → starts are issued in order ARP, ICMP, UDP. `arp_tx_type` = 1. The start pulses are separated by frame length + 12 + 1 cycles.
- Second ICMP request while ICMP is pending (not yet granted) → `req_ovf` pulses once and only one ICMP frame is sent.
- UDP granted and engine never asserts done → `timeout_err` pulses at 4096 cycles after the start. `grant` = 0 during GAP, then a pending ARP request is serviced.
- ICMP granted with `icmp_tx_req` toggling, `tx_data` = 0xA5 → `tx_req` mirrors `icmp_tx_req`. `udp_tx_req` activity is ignored.
- `rst_n` low mid-frame for 1 cycle → the next cycle has all outputs 0, `grant` = 0 and `busy` = 0. A pending request that was queued before the reset is lost.
